// File: rtl/fd_pipe_hme_pkg.sv
// Shared limits and helpers for the fd_pipe_hme elastic register pipeline.
package fd_pipe_hme_pkg;

   localparam int unsigned WIDTH_MIN = 1;
   localparam int unsigned WIDTH_MAX = 1024;
   localparam int unsigned DEPTH_MIN = 1;
   localparam int unsigned DEPTH_MAX = 64;

   // Bits needed to count 0..depth valid stages
   function automatic int unsigned occ_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fd_pipe_hme_stage.sv
// One pipeline stage: data word plus valid bit, with load, flush and reset-to-INIT.
module fd_pipe_hme_stage #(
   parameter int unsigned      WIDTH = 1,
   parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   input  logic             d_vld,
   output logic [WIDTH-1:0] data_q,
   output logic             vld_q
);

   logic [WIDTH-1:0] data_d;
   logic             vld_d;

   // Data only changes when a valid word arrives; an emptied stage keeps its last word
   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      if (clr) begin
         vld_d = 1'b0;
      end else if (load) begin
         vld_d = d_vld;
         if (d_vld) data_d = d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= INIT;
         vld_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
      end
   end

endmodule

// File: rtl/fd_pipe_hme.sv
// Elastic register pipeline with bubble collapsing and a combinational ready chain.
// Optional synchronous flush port CLR when FD_PIPE_HME_CLR_EN is defined.
module fd_pipe_hme
   import fd_pipe_hme_pkg::*;
#(
   parameter int unsigned      WIDTH = 1,
   parameter int unsigned      DEPTH = 2,
   parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
   input  logic                      C,
   input  logic                      R,
   input  logic                      CE,
`ifdef FD_PIPE_HME_CLR_EN
   input  logic                      CLR,
`endif
   input  logic [WIDTH-1:0]          D,
   input  logic                      D_VLD,
   output logic                      D_RDY,
   output logic [WIDTH-1:0]          Q,
   output logic                      Q_VLD,
   input  logic                      Q_RDY,
   output logic [occ_w(DEPTH)-1:0]   OCC
);

   localparam int unsigned OCC_W = occ_w(DEPTH);

   logic             clr_c;
   logic [DEPTH-1:0] vld;
   logic [DEPTH-1:0] load;
   logic [WIDTH-1:0] data [DEPTH];
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             in_xfer, out_xfer;

`ifdef FD_PIPE_HME_CLR_EN
   assign clr_c = CLR & CE;
`else
   assign clr_c = 1'b0;
`endif

   // A stage loads when it is empty or its own word moves on; ripples back from Q_RDY
   always_comb begin
      load = '0;
      load[DEPTH-1] = CE & ~clr_c & (~vld[DEPTH-1] | Q_RDY);
      for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
         load[i] = CE & ~clr_c & (~vld[i] | load[i+1]);
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic [WIDTH-1:0] src_d;
      logic             src_vld;
      if (g == 0) begin : g_head
         assign src_d   = D;
         assign src_vld = D_VLD;
      end else begin : g_body
         assign src_d   = data[g-1];
         assign src_vld = vld[g-1];
      end
      fd_pipe_hme_stage #(
         .WIDTH (WIDTH),
         .INIT  (INIT)
      ) u_stage (
         .clk    (C),
         .rst    (R),
         .load   (load[g]),
         .clr    (clr_c),
         .d      (src_d),
         .d_vld  (src_vld),
         .data_q (data[g]),
         .vld_q  (vld[g])
      );
   end

   assign D_RDY    = load[0];
   assign Q_VLD    = vld[DEPTH-1] & CE & ~clr_c;
   assign Q        = data[DEPTH-1];
   assign in_xfer  = D_VLD & D_RDY;
   assign out_xfer = Q_VLD & Q_RDY;

   always_comb begin
      occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
      if (clr_c) occ_d = '0;
   end

   always_ff @(posedge C) begin
      if (R) occ_q <= '0;
      else   occ_q <= occ_d;
   end

   assign OCC = occ_q;

endmodule

// File: tb/tb_fd_pipe_hme.sv
// Self-checking bench for fd_pipe_hme (WIDTH=8, DEPTH=3, INIT=8'hA5); define
// FD_PIPE_HME_CLR_EN to also exercise the flush port.
module tb_fd_pipe_hme;

   localparam logic [7:0] INIT_V = 8'hA5;

   logic       C = 1'b0;
   logic       R = 1'b1, CE = 1'b0, D_VLD = 1'b0, Q_RDY = 1'b0, CLR = 1'b0;
   logic [7:0] D = '0;
   logic       D_RDY, Q_VLD;
   logic [7:0] Q;
   logic [1:0] OCC;

   int n_cmp = 0;
   int n_err = 0;

   // Reference: three slots, the word last seen at the output, and an in-order queue
   bit         m_vld [3];
   logic [7:0] m_dat [3];
   logic [7:0] m_q;
   logic [7:0] sb [$];

   logic       o_dr, o_qv;
   logic [7:0] o_q;
   logic [1:0] o_occ;

   always #5 C = ~C;

   fd_pipe_hme #(.WIDTH(8), .DEPTH(3), .INIT(8'hA5)) dut (
      .C     (C),
      .R     (R),
      .CE    (CE),
`ifdef FD_PIPE_HME_CLR_EN
      .CLR   (CLR),
`endif
      .D     (D),
      .D_VLD (D_VLD),
      .D_RDY (D_RDY),
      .Q     (Q),
      .Q_VLD (Q_VLD),
      .Q_RDY (Q_RDY),
      .OCC   (OCC)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int m_occ();
      int n = 0;
      for (int j = 0; j < 3; j++) n += int'(m_vld[j]);
      return n;
   endfunction

   function automatic void model_reset();
      for (int j = 0; j < 3; j++) begin
         m_vld[j] = 1'b0;
         m_dat[j] = INIT_V;
      end
      m_q = INIT_V;
      sb.delete();
   endfunction

   // One clock: drive, compare against the reference, then advance the reference
   task automatic step(input bit r, input bit ce, input bit dv, input logic [7:0] d,
                       input bit qr, input bit clr);
      bit act, pop, room, acc;
      int k;
      @(negedge C);
      R = r; CE = ce; D_VLD = dv; D = d; Q_RDY = qr; CLR = clr;
      #1;
      act  = ce && !clr;
      pop  = act && m_vld[2] && qr;
      room = act && (pop || !m_vld[0] || !m_vld[1] || !m_vld[2]);
      acc  = room && dv;
      o_dr = D_RDY; o_qv = Q_VLD; o_q = Q; o_occ = OCC;
      check("d_rdy", 32'(D_RDY), 32'(room));
      check("q_vld", 32'(Q_VLD), 32'(act && m_vld[2]));
      check("q",     32'(Q),     32'(m_q));
      check("occ",   32'(OCC),   32'(m_occ()));
      if (pop) begin
         if (sb.size() > 0) check("order", 32'(Q), 32'(sb.pop_front()));
         else               check("order_cnt", 32'(sb.size()), 32'd1);
      end
      @(posedge C);
      if (r) begin
         model_reset();
      end else if (ce && clr) begin
         for (int j = 0; j < 3; j++) m_vld[j] = 1'b0;
         sb.delete();
      end else if (ce) begin
         if (pop) m_vld[2] = 1'b0;
         k = -1;
         for (int j = 2; j >= 0; j--) begin
            if (!m_vld[j]) begin
               k = j;
               break;
            end
         end
         // Everything upstream of the highest hole shifts one slot toward Q
         if (k >= 0) begin
            for (int j = k; j >= 1; j--) begin
               m_vld[j] = m_vld[j-1];
               m_dat[j] = m_dat[j-1];
            end
            m_vld[0] = dv;
            m_dat[0] = d;
         end
         if (acc) sb.push_back(d);
         if (m_vld[2]) m_q = m_dat[2];
      end
   endtask

   task automatic idle(input bit qr);
      step(1'b0, 1'b1, 1'b0, 8'h00, qr, 1'b0);
   endtask

   initial begin
      int sent, got, first, last, occ_hold;
      bit r, ce, dv, qr, clr;
      int qr_bias;

      R = 1'b1;
      repeat (2) @(posedge C);
      model_reset();

      // Reset state
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      idle(1'b1);
      check("rst_q",    32'(o_q),   32'(INIT_V));
      check("rst_qvld", 32'(o_qv),  32'd0);
      check("rst_occ",  32'(o_occ), 32'd0);
      check("rst_drdy", 32'(o_dr),  32'd1);

      // Single word latency: visible at cycle 3 only
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         idle(1'b1);
         check("lat_qvld", 32'(o_qv), 32'(c == 3));
         check("lat_occ",  32'(o_occ), (c == 4) ? 32'd0 : 32'd1);
         if (c == 3) check("lat_q", 32'(o_q), 32'h01);
      end

      // Backpressure fill, then drain without gaps
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      sent = 0;
      for (int t = 0; t < 6; t++) begin
         step(1'b0, 1'b1, 1'b1, 8'(8'h10 + sent), 1'b0, 1'b0);
         if (o_dr) sent++;
      end
      check("fill_cnt",  32'(sent),  32'd3);
      check("fill_drdy", 32'(o_dr),  32'd0);
      check("fill_occ",  32'(o_occ), 32'd3);
      got = 0; first = -1; last = -1;
      for (int t = 0; t < 12 && got < 5; t++) begin
         step(1'b0, 1'b1, sent < 5, 8'(8'h10 + sent), 1'b1, 1'b0);
         if (o_qv) begin
            check("drain_data", 32'(o_q), 32'(8'h10 + got));
            got++;
            if (first < 0) first = t;
            last = t;
         end
         if (o_dr && sent < 5) sent++;
      end
      check("drain_cnt", 32'(got), 32'd5);
      check("drain_gap", 32'(last - first), 32'd4);

      // Bubble collapse
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      step(1'b0, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      check("bub_occ",  32'(o_occ), 32'd2);
      check("bub_qvld", 32'(o_qv),  32'd1);
      check("bub_q",    32'(o_q),   32'hAA);

      // Clock-enable freeze mid-stream
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 8'h31, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 8'h32, 1'b1, 1'b0);
      occ_hold = m_occ();
      for (int t = 0; t < 4; t++) begin
         step(1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0);
         check("ce0_drdy", 32'(o_dr),  32'd0);
         check("ce0_qvld", 32'(o_qv),  32'd0);
         check("ce0_occ",  32'(o_occ), 32'(occ_hold));
      end
      got = 0;
      for (int t = 0; t < 6; t++) begin
         idle(1'b1);
         if (o_qv) begin
            check("ce0_resume", 32'(o_q), 32'(8'h31 + got));
            got++;
         end
      end
      check("ce0_resume_cnt", 32'(got), 32'd2);

`ifdef FD_PIPE_HME_CLR_EN
      // Flush keeps data, reset with flush reloads INIT
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int t = 0; t < 3; t++) step(1'b0, 1'b1, 1'b1, 8'(8'h50 + t), 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 8'h60, 1'b1, 1'b1);
      check("clr_drdy", 32'(o_dr), 32'd0);
      check("clr_qvld", 32'(o_qv), 32'd0);
      idle(1'b0);
      check("clr_occ",  32'(o_occ), 32'd0);
      check("clr_qvld2", 32'(o_qv), 32'd0);
      check("clr_q",    32'(o_q),   32'h50);
      for (int t = 0; t < 3; t++) step(1'b0, 1'b1, 1'b1, 8'(8'h70 + t), 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      idle(1'b0);
      check("rclr_q",   32'(o_q),   32'(INIT_V));
      check("rclr_occ", 32'(o_occ), 32'd0);
`endif

      // Randomized traffic with bursts of backpressure
      qr_bias = 1;
      for (int t = 0; t < 3000; t++) begin
         if ((t % 200) == 0) qr_bias = int'($urandom_range(3));
         r   = ($urandom_range(63) == 0);
         ce  = ($urandom_range(7) != 0);
         dv  = ($urandom_range(3) != 0);
         qr  = (int'($urandom_range(3)) <= qr_bias);
`ifdef FD_PIPE_HME_CLR_EN
         clr = ($urandom_range(49) == 0);
`else
         clr = 1'b0;
`endif
         step(r, ce, dv, 8'($urandom), qr, clr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fd_pipe_hme.md
FD_PIPE_HME -- requirements
Module: fd_pipe_hme

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data bits per stage (1..1024).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (1..64).
REQ-003 SHALL have parameter INIT, default {WIDTH{1'b0}}, data value loaded into every stage on reset.
REQ-004 SHALL have port C  input  1  clock, single clock domain, all state on rising edge.
REQ-005 SHALL have port R  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port CE  input  1  global clock enable; 0 freezes all state.
REQ-007 SHALL have port D  input  WIDTH  write data.
REQ-008 SHALL have port D_VLD  input  1  write data valid.
REQ-009 SHALL have port D_RDY  output  1  pipeline accepts D this cycle.
REQ-010 SHALL have port Q  output  WIDTH  data of last stage.
REQ-011 SHALL have port Q_VLD  output  1  last stage holds valid data.
REQ-012 SHALL have port Q_RDY  input  1  consumer accepts Q this cycle.
REQ-013 SHALL have port OCC  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-014 Each stage i (0..DEPTH-1) SHALL hold one data word and one valid bit; stage 0 is fed by D, stage DEPTH-1 drives Q.
REQ-015 Output transfer SHALL occur when Q_VLD && Q_RDY; input transfer SHALL occur when D_VLD && D_RDY.
REQ-016 Q_VLD SHALL equal valid[DEPTH-1] && CE; Q SHALL equal data[DEPTH-1] regardless of valid.
REQ-017 Stage i SHALL advance (load from stage i-1 or D) when CE=1 and (stage i empty or stage i is itself advancing out); empty stages SHALL be filled so bubbles collapse.
REQ-018 D_RDY SHALL equal CE && (!valid[0] || stage 0 advancing); the ready chain is combinational from Q_RDY.
REQ-019 A stage that is not loaded SHALL hold its data; a stage emptied without reload SHALL clear its valid and keep its data.
REQ-020 With CE=1, Q_RDY=1 and empty pipeline, a word accepted at cycle n SHALL appear with Q_VLD=1 at cycle n+DEPTH.
REQ-021 Full pipeline (OCC=DEPTH) with Q_RDY=1 SHALL sustain one transfer per cycle with D_RDY=1 (simultaneous in/out).
REQ-022 Full pipeline with Q_RDY=0 SHALL drive D_RDY=0 and hold all data.
REQ-023 OCC SHALL update each cycle as OCC + in_xfer - out_xfer, never exceeding DEPTH nor wrapping below 0.
REQ-024 CE=0 SHALL force D_RDY=0 and Q_VLD=0 and hold all data, valid bits and OCC.

Reset
REQ-025 R=1 at a rising edge SHALL clear all valid bits, load INIT into all data stages, and set OCC=0, with priority over CE and handshakes.
REQ-026 Reset mid-transfer SHALL drop in-flight words; the cycle after R deasserts, Q=INIT, Q_VLD=0, D_RDY=CE.

Configuration
REQ-027 Macro FD_PIPE_HME_CLR_EN defined SHALL add port CLR  input  1  synchronous flush.
REQ-028 With FD_PIPE_HME_CLR_EN: CLR=1 && CE=1 SHALL clear all valid bits and OCC, keep data, force D_RDY=0 and Q_VLD=0 that cycle; R has priority over CLR.
REQ-029 Without FD_PIPE_HME_CLR_EN the CLR port and logic SHALL be absent; behaviour per REQ-014..026 only.

Structure
REQ-030 Package fd_pipe_hme_pkg SHALL hold the occupancy-width function and the DEPTH/WIDTH limit constants.
REQ-031 One sub-module fd_pipe_hme_stage (data+valid register with load/clear/INIT) SHALL be instantiated DEPTH times via generate.

Verification
REQ-032 WIDTH=8, DEPTH=3, INIT=8'hA5: assert R 1 cycle -> Q=8'hA5, Q_VLD=0, OCC=0, D_RDY=1.
REQ-033 Send 8'h01 at cycle 0, Q_RDY=1 -> Q_VLD=1, Q=8'h01 at cycle 3 only; OCC 1,1,1,0.
REQ-034 Q_RDY=0, stream 8'h10..8'h14 -> first 3 accepted, D_RDY=0 after, OCC=3; release Q_RDY -> 8'h10,11,12,13,14 in order, no gaps after refill.
REQ-035 Single word then 2 idle cycles then second word, Q_RDY=0 -> both collapse to stages 2 and 1, OCC=2.
REQ-036 CE=0 for 4 cycles mid-stream -> D_RDY=0, Q_VLD=0, data and OCC unchanged; stream resumes intact.
REQ-037 With FD_PIPE_HME_CLR_EN, full pipeline, CLR 1 cycle -> OCC=0, Q_VLD=0, Q retains last data word; R asserted with CLR -> Q=INIT.
